hazard_scoreboard: RTL and testbench

//  Parametrised hazard/forwarding unit for the in-order pipeline. Per ID read port, selects a forwarding source

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_fwd_match.sv | 42 ++++
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 tb/tb_hazard_scoreboard.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants, FSM type and select-width helper for the hazard unit
package hazard_pkg;

  localparam int         FWD_RF   = 0;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  function automatic int selw(input int nstg);
    return $clog2(nstg + 1);
  endfunction

endpackage

// File: rtl/hazard_fwd_match.sv
// rtl/hazard_fwd_match.sv - per-read-port youngest-stage forwarding match and hazard flag
module hazard_fwd_match
  import hazard_pkg::*;
#(
  parameter int NSTG    = 3,
  parameter int BR_FMIN = 1,
  parameter int SELW    = 2
) (
  input  logic              rused,
  input  logic [4:0]        raddr,
  input  logic              id_branch,
  input  logic [NSTG-1:0]   stg_valid,
  input  logic [NSTG-1:0]   stg_we,
  input  logic [NSTG*5-1:0] stg_dest,
  input  logic [NSTG-1:0]   stg_rdy,
  output logic [SELW-1:0]   sel,
  output logic              hazard
);

  logic [NSTG-1:0] hit;

  always_comb begin
    hit = '0;
    for (int s = 0; s < NSTG; s++) begin
      hit[s] = rused & (raddr != REG_ZERO) & stg_valid[s] & stg_we[s] &
               (stg_dest[5*s +: 5] == raddr);
    end
  end

  // Scan oldest to youngest so the youngest matching stage is the last to assign.
  always_comb begin
    sel    = SELW'(FWD_RF);
    hazard = 1'b0;
    for (int s = NSTG - 1; s >= 0; s--) begin
      if (hit[s]) begin
        sel    = SELW'(s + 1);
        hazard = ~stg_rdy[s] | (id_branch & (s < BR_FMIN));
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - forwarding select, ID stall, long-op scoreboard, drain FSM and watchdog (HAZARD_WDOG_EN)
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NRD     = 2,
  parameter  int NSTG    = 3,
  parameter  int BR_FMIN = 1,
  parameter  int WDOG_W  = 8,
  localparam int SELW    = selw(NSTG)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic [NRD*5-1:0]  id_raddr,
  input  logic [NRD-1:0]    id_rused,
  input  logic              id_branch,
  input  logic              id_serial,
  input  logic              id_long,
  input  logic [4:0]        id_dest,
  input  logic              id_fire,
  input  logic [NSTG-1:0]   stg_valid,
  input  logic [NSTG-1:0]   stg_we,
  input  logic [NSTG*5-1:0] stg_dest,
  input  logic [NSTG-1:0]   stg_rdy,
  input  logic              long_done,
  input  logic [4:0]        long_dest,
  input  logic              flush,
  output logic [NRD*SELW-1:0] fwd_sel,
  output logic              stall_id,
  output logic              wdog_err
);

  logic [31:0]    pending_q, pending_d;
  drain_state_e   state_q;
  logic [NRD-1:0] match_haz;
  logic [NRD-1:0] port_haz;
  logic           any_stg, any_pend, waw, serial_hold;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    hazard_fwd_match #(
      .NSTG    (NSTG),
      .BR_FMIN (BR_FMIN),
      .SELW    (SELW)
    ) u_match (
      .rused     (id_rused[p]),
      .raddr     (id_raddr[5*p +: 5]),
      .id_branch (id_branch),
      .stg_valid (stg_valid),
      .stg_we    (stg_we),
      .stg_dest  (stg_dest),
      .stg_rdy   (stg_rdy),
      .sel       (fwd_sel[p*SELW +: SELW]),
      .hazard    (match_haz[p])
    );
    assign port_haz[p] = match_haz[p] | (id_rused[p] & pending_q[id_raddr[5*p +: 5]]);
  end

  assign any_stg     = |stg_valid;
  assign any_pend    = |pending_q;
  assign waw         = id_long & (id_dest != REG_ZERO) & pending_q[id_dest];
  // A serialising op in IDLE is held on the cycle it triggers the drain, not just once DRAIN is entered.
  assign serial_hold = (state_q == DRAIN) | (id_serial & (any_stg | any_pend));
  assign stall_id    = id_valid & ((|port_haz) | waw | serial_hold);

  // Clear before set so a new issue to a register retiring this cycle stays pending.
  always_comb begin
    pending_d = pending_q;
    if (long_done) pending_d[long_dest] = 1'b0;
    if (id_fire & id_long) pending_d[id_dest] = 1'b1;
    pending_d[REG_ZERO] = 1'b0;
    if (flush) pending_d = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (id_valid & id_serial & (any_stg | any_pend)) state_q <= DRAIN;
        DRAIN:   if (!any_stg & !any_pend) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_err_q;

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (flush | ~stall_id)      wdog_cnt_d = '0;
    else if (~&wdog_cnt_q)      wdog_cnt_d = wdog_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_q | (&wdog_cnt_d);
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and randomized checks of hazard_scoreboard against a behavioural model
module tb_hazard_scoreboard;

  localparam int NRD     = 2;
  localparam int NSTG    = 3;
  localparam int BR_FMIN = 1;
  localparam int WDOG_W  = 4;
  localparam int WMAX    = (1 << WDOG_W) - 1;
`ifdef HAZARD_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_valid, id_branch, id_serial, id_long, id_fire;
  logic [9:0]  id_raddr;
  logic [1:0]  id_rused;
  logic [4:0]  id_dest;
  logic [2:0]  stg_valid, stg_we, stg_rdy;
  logic [14:0] stg_dest;
  logic        long_done, flush;
  logic [4:0]  long_dest;
  logic [3:0]  fwd_sel;
  logic        stall_id, wdog_err;

  hazard_scoreboard #(
    .NRD(NRD), .NSTG(NSTG), .BR_FMIN(BR_FMIN), .WDOG_W(WDOG_W)
  ) dut (
    .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_raddr(id_raddr),
    .id_rused(id_rused), .id_branch(id_branch), .id_serial(id_serial),
    .id_long(id_long), .id_dest(id_dest), .id_fire(id_fire),
    .stg_valid(stg_valid), .stg_we(stg_we), .stg_dest(stg_dest), .stg_rdy(stg_rdy),
    .long_done(long_done), .long_dest(long_dest), .flush(flush),
    .fwd_sel(fwd_sel), .stall_id(stall_id), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  int n_chk, n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference state: which registers await a long op, whether we are draining, stall run length.
  bit [31:0] m_pend;
  bit        m_drain;
  int        m_wcnt;
  bit        m_werr;
  logic [3:0] exp_sel;
  logic       exp_stall;

  task automatic model_reset();
    m_pend = '0; m_drain = 0; m_wcnt = 0; m_werr = 0;
  endtask

  function automatic bit stage_writes(int s, logic [4:0] r);
    return stg_valid[s] && stg_we[s] && (stg_dest[5*s +: 5] == r);
  endfunction

  task automatic model_eval();
    bit haz;
    logic [4:0] r;
    int win;
    haz = 0;
    exp_sel = '0;
    for (int p = 0; p < NRD; p++) begin
      r = id_raddr[5*p +: 5];
      win = -1;
      if (id_rused[p] && r != 0)
        for (int s = 0; s < NSTG; s++) if (win < 0 && stage_writes(s, r)) win = s;
      if (win >= 0) begin
        exp_sel[2*p +: 2] = 2'(win + 1);
        if (!stg_rdy[win] || (id_branch && win < BR_FMIN)) haz = 1;
      end
      if (id_rused[p] && m_pend[r]) haz = 1;
    end
    if (id_long && id_dest != 0 && m_pend[id_dest]) haz = 1;
    if (m_drain || (id_serial && (stg_valid != 0 || m_pend != 0))) haz = 1;
    exp_stall = id_valid && haz;
  endtask

  task automatic model_update();
    model_eval();
    if (flush) begin
      m_pend = '0; m_drain = 0; m_wcnt = 0;
    end else begin
      if (!m_drain && id_valid && id_serial && (stg_valid != 0 || m_pend != 0)) m_drain = 1;
      else if (m_drain && stg_valid == 0 && m_pend == 0) m_drain = 0;
      if (long_done) m_pend[long_dest] = 0;
      if (id_fire && id_long && id_dest != 0) m_pend[id_dest] = 1;
      if (exp_stall) begin
        if (m_wcnt < WMAX) m_wcnt++;
        if (m_wcnt == WMAX) m_werr = 1;
      end else begin
        m_wcnt = 0;
      end
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_branch = 0; id_serial = 0; id_long = 0; id_fire = 0;
    id_raddr = '0; id_rused = '0; id_dest = '0;
    stg_valid = '0; stg_we = '0; stg_rdy = '0; stg_dest = '0;
    long_done = 0; long_dest = '0; flush = 0;
  endtask

  task automatic set_stg(input int s, input logic [4:0] d, input logic rdy);
    stg_valid[s] = 1; stg_we[s] = 1; stg_dest[5*s +: 5] = d; stg_rdy[s] = rdy;
  endtask

  task automatic set_rd(input int p, input logic [4:0] r);
    id_rused[p] = 1; id_raddr[5*p +: 5] = r;
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_model(input string tag);
    model_eval();
    check({tag, "_sel"}, fwd_sel, exp_sel);
    check({tag, "_stall"}, stall_id, exp_stall);
    check({tag, "_werr"}, wdog_err, WDOG_ON ? m_werr : 1'b0);
  endtask

  task automatic pulse_reset();
    resetn = 0;
    model_reset();
    #1;
    check("rst_werr", wdog_err, 0);
    @(posedge clk);
    #1 resetn = 1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    resetn = 0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    check("reset_sel", fwd_sel, 0);
    check("reset_stall", stall_id, 0);
    check("reset_werr", wdog_err, 0);
    @(posedge clk);
    #1 resetn = 1;

    // EX forwards r5; a MEM writer of r5 does not override the younger EX one
    id_valid = 1; set_rd(0, 5); set_stg(0, 5, 1);
    @(negedge clk);
    check("ex_fwd_sel", fwd_sel[1:0], 1);
    check("ex_fwd_stall", stall_id, 0);
    adv();
    set_stg(1, 5, 1);
    @(negedge clk);
    check("youngest_sel", fwd_sel[1:0], 1);
    check("youngest_stall", stall_id, 0);
    adv();

    // load-use on r7, then the load reaches MEM with data
    clear_inputs(); id_valid = 1; set_rd(0, 7); set_stg(0, 7, 0);
    @(negedge clk);
    check("loaduse_stall", stall_id, 1);
    adv();
    clear_inputs(); id_valid = 1; set_rd(0, 7); set_stg(1, 7, 1);
    @(negedge clk);
    check("load_mem_sel", fwd_sel[1:0], 2);
    check("load_mem_stall", stall_id, 0);
    adv();

    // branch compare may not forward from EX
    clear_inputs(); id_valid = 1; id_branch = 1; set_rd(1, 3); set_stg(0, 3, 1);
    @(negedge clk);
    check("br_ex_stall", stall_id, 1);
    adv();
    clear_inputs(); id_valid = 1; id_branch = 1; set_rd(1, 3); set_stg(1, 3, 1);
    @(negedge clk);
    check("br_mem_sel", fwd_sel[3:2], 2);
    check("br_mem_stall", stall_id, 0);
    adv();

    // long-latency div to r9 and its consumer
    clear_inputs(); id_valid = 1; id_long = 1; id_dest = 9; id_fire = 1;
    @(negedge clk);
    check("div_issue_stall", stall_id, 0);
    adv();
    clear_inputs(); id_valid = 1; set_rd(0, 9);
    @(negedge clk);
    check("div_use_stall", stall_id, 1);
    adv();
    long_done = 1; long_dest = 9;
    @(negedge clk);
    check("div_done_stall", stall_id, 1);
    adv();
    long_done = 0;
    @(negedge clk);
    check("div_after_stall", stall_id, 0);
    adv();

    // serialising op drains the pipe
    clear_inputs(); id_valid = 1; id_serial = 1; stg_valid = 3'b001;
    @(negedge clk);
    check("ser_busy_stall", stall_id, 1);
    adv();
    stg_valid = 3'b000;
    @(negedge clk);
    check("ser_drain_stall", stall_id, 1);
    adv();
    @(negedge clk);
    check("ser_idle_stall", stall_id, 0);
    adv();

    // flush while draining on a pending register
    clear_inputs(); id_valid = 1; id_long = 1; id_dest = 4; id_fire = 1;
    adv();
    clear_inputs(); id_valid = 1; id_serial = 1;
    @(negedge clk);
    check("ser_pend_stall", stall_id, 1);
    adv();
    clear_inputs(); flush = 1;
    adv();
    clear_inputs(); id_valid = 1; id_serial = 1; set_rd(0, 4);
    @(negedge clk);
    check("post_flush_stall", stall_id, 0);
    adv();

    // watchdog on a held load-use stall
    clear_inputs(); id_valid = 1; set_rd(0, 7); set_stg(0, 7, 0);
    for (int i = 0; i < WMAX; i++) begin
      @(negedge clk);
      check("wdog_early", wdog_err, 0);
      adv();
    end
    @(negedge clk);
    check("wdog_fire", wdog_err, WDOG_ON);
    adv();
    clear_inputs();
    @(negedge clk);
    check("wdog_sticky", wdog_err, WDOG_ON);
    check("wdog_nostall", stall_id, 0);
    adv();
    pulse_reset();

    // randomized traffic against the model
    for (int it = 0; it < 1500; it++) begin
      clear_inputs();
      id_valid  = ($urandom_range(0, 9) != 0);
      id_branch = ($urandom_range(0, 4) == 0);
      id_serial = ($urandom_range(0, 19) == 0);
      id_long   = ($urandom_range(0, 6) == 0);
      id_dest   = 5'($urandom_range(0, 7));
      id_rused  = 2'($urandom_range(0, 3));
      id_raddr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      stg_valid = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      stg_we    = 3'($urandom_range(0, 7));
      stg_rdy   = 3'($urandom_range(0, 7));
      for (int s = 0; s < NSTG; s++) stg_dest[5*s +: 5] = 5'($urandom_range(0, 7));
      long_done = ($urandom_range(0, 4) == 0);
      long_dest = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 39) == 0);
      model_eval();
      id_fire   = id_valid && !exp_stall && ($urandom_range(0, 1) == 1);
      if (it == 700) begin
        resetn = 0;
        model_reset();
        @(negedge clk);
        check_model("midrst");
        @(posedge clk);
        #1 resetn = 1;
      end else begin
        @(negedge clk);
        check_model("rnd");
        adv();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
